// File: rtl/interleaver_pkg.sv
// Shared widths, lane count and FSM state encoding for the stage-2 interleaver.
package interleaver_pkg;

  localparam int unsigned KW     = 13;
  localparam int unsigned TW     = 15;
  localparam int unsigned NLANES = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/interleaver_mod_add.sv
// Combinational (a + b) mod k for a, b < k: one conditional subtraction.
module interleaver_mod_add #(
  parameter int unsigned AW = 13,
  parameter int unsigned BW = 15
) (
  input  logic [AW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  input  logic [AW-1:0] k_i,
  output logic [AW-1:0] sum_c
);

  localparam int unsigned SW = ((AW > BW) ? AW : BW) + 1;

  logic [SW-1:0] s_c;

  assign s_c   = SW'(a_i) + SW'(b_i);
  assign sum_c = (s_c >= SW'(k_i)) ? AW'(s_c - SW'(k_i)) : AW'(s_c);

endmodule

// File: rtl/interleaver_stage_2.sv
// Four-lane QPP interleaver address generator fed by per-beat deltas.
// Optional sticky range-check output err: define INTERLEAVER_STAGE_2_RANGE_CHECK_EN.
module interleaver_stage_2 #(
  parameter int unsigned KW = interleaver_pkg::KW,
  parameter int unsigned TW = interleaver_pkg::TW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KW-1:0]     K_i,
  input  logic              start,
  input  logic [KW-1:0]     init_k4,
  input  logic [KW-1:0]     init_k2,
  input  logic [KW-1:0]     init_3k4,
  input  logic              in_valid,
  input  logic [TW-1:0]     theta_0,
  input  logic [TW-1:0]     theta_1,
  output logic              out_valid,
  output logic [4*KW-1:0]   pi_even,
  output logic [4*KW-1:0]   pi_odd,
  output logic              done
`ifdef INTERLEAVER_STAGE_2_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  import interleaver_pkg::*;

  localparam int unsigned CW = KW - 3;

  state_e                        state_q, state_d;
  logic [NLANES-1:0][KW-1:0]     acc_q, acc_d;
  logic [NLANES-1:0][KW-1:0]     pe_q, pe_d;
  logic [NLANES-1:0][KW-1:0]     po_q, po_d;
  logic [NLANES-1:0][KW-1:0]     odd_c, nxt_c;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [CW-1:0]                 last_c;
  logic                          ov_q, ov_d;
  logic                          done_q, done_d;
  logic                          beat_c;

  assign last_c = CW'(K_i >> 3) - CW'(1);
  assign beat_c = (state_q == RUN) && in_valid && !start;

  // Per lane: odd address = acc + theta_0, next even address = odd + theta_1.
  for (genvar m = 0; m < NLANES; m++) begin : g_lane
    interleaver_mod_add #(.AW(KW), .BW(TW)) u_add_odd (
      .a_i  (acc_q[m]),
      .b_i  (theta_0),
      .k_i  (K_i),
      .sum_c(odd_c[m])
    );
    interleaver_mod_add #(.AW(KW), .BW(TW)) u_add_nxt (
      .a_i  (odd_c[m]),
      .b_i  (theta_1),
      .k_i  (K_i),
      .sum_c(nxt_c[m])
    );
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pe_d    = pe_q;
    po_d    = po_q;
    ov_d    = 1'b0;
    done_d  = 1'b0;
    if (start) begin
      state_d  = RUN;
      acc_d[0] = '0;
      acc_d[1] = init_k4;
      acc_d[2] = init_k2;
      acc_d[3] = init_3k4;
      cnt_d    = '0;
    end else if (beat_c) begin
      pe_d  = acc_q;
      po_d  = odd_c;
      acc_d = nxt_c;
      ov_d  = 1'b1;
      if (cnt_q == last_c) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      pe_q    <= '0;
      po_q    <= '0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pe_q    <= pe_d;
      po_q    <= po_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = ov_q;
  assign pi_even   = pe_q;
  assign pi_odd    = po_q;
  assign done      = done_q;

`ifdef INTERLEAVER_STAGE_2_RANGE_CHECK_EN
  localparam int unsigned CMPW = ((KW > TW) ? KW : TW) + 1;

  logic err_q, err_d;

  // Sticky flag; a new start re-arms it from the K_i alignment check.
  always_comb begin
    err_d = err_q;
    if (start) begin
      err_d = (K_i[2:0] != 3'd0);
    end else if (beat_c && ((CMPW'(theta_0) >= CMPW'(K_i)) ||
                            (CMPW'(theta_1) >= CMPW'(K_i)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_interleaver_stage_2.sv
// Scoreboard bench for interleaver_stage_2: modulo model pushes expected beats, monitor pops them.
module tb_interleaver_stage_2;

  localparam int unsigned KW = 13;
  localparam int unsigned TW = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [KW-1:0]   K_i = '0;
  logic            start = 1'b0;
  logic [KW-1:0]   init_k4 = '0, init_k2 = '0, init_3k4 = '0;
  logic            in_valid = 1'b0;
  logic [TW-1:0]   theta_0 = '0, theta_1 = '0;
  logic            out_valid;
  logic [4*KW-1:0] pi_even, pi_odd;
  logic            done;
`ifdef INTERLEAVER_STAGE_2_RANGE_CHECK_EN
  logic            err;
`endif

  interleaver_stage_2 #(.KW(KW), .TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .K_i      (K_i),
    .start    (start),
    .init_k4  (init_k4),
    .init_k2  (init_k2),
    .init_3k4 (init_3k4),
    .in_valid (in_valid),
    .theta_0  (theta_0),
    .theta_1  (theta_1),
    .out_valid(out_valid),
    .pi_even  (pi_even),
    .pi_odd   (pi_odd),
    .done     (done)
`ifdef INTERLEAVER_STAGE_2_RANGE_CHECK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*KW-1:0] pe;
    logic [4*KW-1:0] po;
    logic            dn;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ov_cnt = 0;
  int   done_cnt = 0;

  int   macc[4];
  int   mk = 40;
  bit   mrun = 1'b0;
  int   mcnt = 0;

  int   th0[5], th1[5];
  logic [4*KW-1:0] cap_pe[5], cap_po[5];

  function automatic logic [4*KW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [4*KW-1:0] v;
    v = '0;
    v[0*KW +: KW] = KW'(l0);
    v[1*KW +: KW] = KW'(l1);
    v[2*KW +: KW] = KW'(l2);
    v[3*KW +: KW] = KW'(l3);
    return v;
  endfunction

  // Output monitor: every out_valid must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && done && !out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL done_without_valid: done=%0b out_valid=%0b required out_valid=1", done, out_valid);
    end
    if (!rst && out_valid) begin
      exp_t e;
      vectors++;
      ov_cnt++;
      if (done) done_cnt++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: out_valid=1 with empty scoreboard, pi_even=%h", pi_even);
      end else begin
        e = sb.pop_front();
        if ({pi_even, pi_odd, done} !== {e.pe, e.po, e.dn}) begin
          miscompares++;
          $display("FAIL beat: got pe=%h po=%h done=%0b, required pe=%h po=%h done=%0b",
                   pi_even, pi_odd, done, e.pe, e.po, e.dn);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int k, input int i1, input int i2, input int i3, input bit with_beat);
    K_i      = KW'(k);
    init_k4  = KW'(i1);
    init_k2  = KW'(i2);
    init_3k4 = KW'(i3);
    start    = 1'b1;
    in_valid = with_beat;
    theta_0  = TW'(7);
    theta_1  = TW'(9);
    mk = k; macc[0] = 0; macc[1] = i1; macc[2] = i2; macc[3] = i3;
    mrun = 1'b1; mcnt = 0;
    cyc(1);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic beat(input int t0, input int t1);
    exp_t e;
    int   po[4];
    in_valid = 1'b1;
    theta_0  = TW'(t0);
    theta_1  = TW'(t1);
    if (mrun) begin
      for (int m = 0; m < 4; m++) po[m] = (macc[m] + t0) % mk;
      e.pe = pack4(macc[0], macc[1], macc[2], macc[3]);
      e.po = pack4(po[0], po[1], po[2], po[3]);
      e.dn = (mcnt == mk / 8 - 1);
      for (int m = 0; m < 4; m++) macc[m] = (po[m] + t1) % mk;
      sb.push_back(e);
      mcnt++;
      if (e.dn) mrun = 1'b0;
    end
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    cyc(3);
    vectors++;
    if ({out_valid, done, pi_even, pi_odd} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ov=%0b done=%0b pe=%h po=%h, required all 0", out_valid, done, pi_even, pi_odd);
    end
    rst = 1'b0;
    cyc(2);
    in_valid = 1'b1;
    cyc(2);
    in_valid = 1'b0;
    cyc(1);
    vectors++;
    if (ov_cnt !== 0) begin
      miscompares++;
      $display("FAIL idle_ignore: got %0d out_valid, required 0", ov_cnt);
    end
  endtask

  task automatic test_directed();
    do_start(40, 30, 20, 10, 1'b0);
    beat(13, 33);
    vectors++;
    if (pi_even !== pack4(0, 30, 20, 10) || pi_odd !== pack4(13, 3, 33, 23)) begin
      miscompares++;
      $display("FAIL directed_first_beat: got pe=%h po=%h, required pe=%h po=%h",
               pi_even, pi_odd, pack4(0, 30, 20, 10), pack4(13, 3, 33, 23));
    end
    cyc(1);
  endtask

  task automatic test_block();
    int ov0, dn0;
    do_start(40, 30, 20, 10, 1'b0);
    ov0 = ov_cnt; dn0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      th0[i] = $urandom_range(39, 0);
      th1[i] = $urandom_range(39, 0);
      beat(th0[i], th1[i]);
      cap_pe[i] = pi_even;
      cap_po[i] = pi_odd;
    end
    cyc(1);
    beat(5, 6);
    cyc(2);
    vectors++;
    if (ov_cnt - ov0 !== 5 || done_cnt - dn0 !== 1) begin
      miscompares++;
      $display("FAIL block_counts: got %0d valid %0d done, required 5 valid 1 done", ov_cnt - ov0, done_cnt - dn0);
    end
  endtask

  task automatic test_gaps();
    do_start(40, 30, 20, 10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      beat(th0[i], th1[i]);
      vectors++;
      if (pi_even !== cap_pe[i] || pi_odd !== cap_po[i]) begin
        miscompares++;
        $display("FAIL gap_vs_nogap beat%0d: got pe=%h po=%h, required pe=%h po=%h",
                 i, pi_even, pi_odd, cap_pe[i], cap_po[i]);
      end
      for (int g = 0; g < 2; g++) begin
        cyc(1);
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL gap_valid: got out_valid=%0b, required 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_start_collide();
    int ov0;
    ov0 = ov_cnt;
    do_start(48, 11, 22, 33, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || ov_cnt !== ov0) begin
      miscompares++;
      $display("FAIL start_collide_valid: got out_valid=%0b, required 0", out_valid);
    end
    beat(0, 0);
    vectors++;
    if (pi_even !== pack4(0, 11, 22, 33)) begin
      miscompares++;
      $display("FAIL start_collide_lanes: got pe=%h, required %h", pi_even, pack4(0, 11, 22, 33));
    end
    cyc(1);
  endtask

  task automatic test_reset_mid();
    int ov0, dn0;
    do_start(40, 30, 20, 10, 1'b0);
    beat(3, 4);
    beat(5, 6);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, done, pi_even, pi_odd} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got ov=%0b done=%0b pe=%h po=%h, required all 0", out_valid, done, pi_even, pi_odd);
    end
    sb.delete();
    mrun = 1'b0;
    cyc(2);
    rst = 1'b0;
    ov0 = ov_cnt; dn0 = done_cnt;
    beat(1, 2);
    cyc(3);
    vectors++;
    if (ov_cnt !== ov0 || done_cnt !== dn0) begin
      miscompares++;
      $display("FAIL reset_mid_discard: got %0d valid %0d done after reset, required 0 0", ov_cnt - ov0, done_cnt - dn0);
    end
    do_start(40, 30, 20, 10, 1'b0);
    for (int i = 0; i < 5; i++) beat($urandom_range(39, 0), $urandom_range(39, 0));
    cyc(2);
    vectors++;
    if (ov_cnt - ov0 !== 5 || done_cnt - dn0 !== 1) begin
      miscompares++;
      $display("FAIL reset_mid_rerun: got %0d valid %0d done, required 5 1", ov_cnt - ov0, done_cnt - dn0);
    end
  endtask

  task automatic test_back_to_back();
    int ov0, dn0;
    do_start(6144, $urandom_range(6143, 0), $urandom_range(6143, 0), $urandom_range(6143, 0), 1'b0);
    ov0 = ov_cnt; dn0 = done_cnt;
    for (int i = 0; i < 768; i++) beat($urandom_range(6143, 0), $urandom_range(6143, 0));
    cyc(2);
    vectors++;
    if (ov_cnt - ov0 !== 768 || done_cnt - dn0 !== 1) begin
      miscompares++;
      $display("FAIL kmax_counts: got %0d valid %0d done, required 768 1", ov_cnt - ov0, done_cnt - dn0);
    end
  endtask

  task automatic test_abort();
    int dn0;
    dn0 = done_cnt;
    do_start(40, 30, 20, 10, 1'b0);
    beat(1, 1);
    beat(2, 2);
    do_start(40, 8, 16, 24, 1'b0);
    for (int i = 0; i < 4; i++) beat(i, i + 1);
    cyc(2);
    vectors++;
    if (done_cnt !== dn0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done, required 0", done_cnt - dn0);
    end
    beat(9, 9);
    cyc(2);
    vectors++;
    if (done_cnt - dn0 !== 1) begin
      miscompares++;
      $display("FAIL abort_restart_done: got %0d done, required 1", done_cnt - dn0);
    end
  endtask

`ifdef INTERLEAVER_STAGE_2_RANGE_CHECK_EN
  task automatic test_range_check();
    do_start(40, 30, 20, 10, 1'b0);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_after_start: got %0b, required 0", err);
    end
    beat(40, 5);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got %0b, required 1", err);
    end
    beat(3, 4);
    cyc(2);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %0b, required 1", err);
    end
    sb.delete();
    do_start(40, 30, 20, 10, 1'b0);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %0b, required 0", err);
    end
    mrun = 1'b0;
    do_start(41, 0, 0, 0, 1'b0);
    mrun = 1'b0;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_k_align: got %0b, required 1", err);
    end
    do_start(40, 0, 0, 0, 1'b0);
    mrun = 1'b0;
    cyc(1);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_block();
    test_gaps();
    test_start_collide();
    test_reset_mid();
    test_abort();
    test_back_to_back();
`ifdef INTERLEAVER_STAGE_2_RANGE_CHECK_EN
    test_range_check();
`endif
    cyc(2);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending beats, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interleaver_stage_2.md
INTERLEAVER_STAGE_2 -- requirements
Module: interleaver_stage_2

Interface
REQ-001 SHALL have parameter KW, default 13, width of K and of every address.
REQ-002 SHALL have parameter TW, default 15, width of the delta inputs.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port K_i  input  KW  block length K, a multiple of 8 in 40..6144, stable from start to done.
REQ-006 SHALL have port start  input  1  one-cycle pulse that loads the lane initial values and begins a block.
REQ-007 SHALL have port init_k4, init_k2, init_3k4  input  KW each  Π(K/4), Π(K/2), Π(3K/4) from stage 1.
REQ-008 SHALL have port in_valid  input  1  a delta beat is present.
REQ-009 SHALL have port theta_0, theta_1  input  TW each  δ(2i), δ(2i+1), each already reduced below K.
REQ-010 SHALL have port out_valid  output  1  pi_even and pi_odd hold a beat.
REQ-011 SHALL have port pi_even, pi_odd  output  4*KW each  lane m in bits [KW*m+KW-1 : KW*m].
REQ-012 SHALL have port done  output  1  one-cycle pulse coincident with the last out_valid of a block.

Function
REQ-013 SHALL hold four lane accumulators; lane m tracks Π(2i + m*K/4) (m = 0..3); all lanes share the same delta because f2 is even.
REQ-014 On start, SHALL load acc0=0, acc1=init_k4, acc2=init_k2, acc3=init_3k4, clear the beat counter, and enter RUN.
REQ-015 In RUN with in_valid, SHALL register pi_even lane m = acc_m and pi_odd lane m = (acc_m+theta_0) mod K, and assert out_valid on the next cycle (latency 1).
REQ-016 On the same edge, SHALL update acc_m to ((acc_m+theta_0) mod K + theta_1) mod K.
REQ-017 Every mod-K add SHALL be computed as s=a+b at KW+1 bits, with s-K taken if s>=K; inputs are < K, so one subtraction suffices.
REQ-018 SHALL use states IDLE and RUN: IDLE->RUN on start; RUN->IDLE after beat K/8 is accepted; any state->RUN on start.
REQ-019 The beat counter SHALL be KW-3 bits wide; beat index K/8-1 is the last beat, and done SHALL assert with the corresponding out_valid.
REQ-020 in_valid in IDLE SHALL be ignored: no out_valid and no state change.
REQ-021 start with in_valid in the same cycle SHALL give start priority; that beat is dropped.
REQ-022 start in RUN SHALL abort the block silently (no done) and reload the lanes.
REQ-023 A cycle in RUN without in_valid SHALL hold all state, and out_valid SHALL be 0 on the next cycle.

Reset
REQ-024 While rst=1, state SHALL be IDLE and acc, counter, pi_even, pi_odd, out_valid and done SHALL be 0.
REQ-025 Reset asserted mid-block SHALL discard the block; no done SHALL follow the deassertion of reset.

Configuration
REQ-026 With INTERLEAVER_STAGE_2_RANGE_CHECK_EN defined, SHALL add output err (1 bit): sticky, set when an accepted beat has theta_0>=K or theta_1>=K, or when start sees K_i[2:0]!=0.
REQ-027 With the macro defined, err SHALL be cleared by rst or start.
REQ-028 Without the macro, the err port and its logic SHALL be absent.

Structure
REQ-029 Package interleaver_pkg SHALL hold KW, TW, lane count 4, and the state enum.
REQ-030 One sub-module, interleaver_mod_add (a, b, K -> (a+b) mod K, combinational), SHALL be instantiated eight times (two per lane).

Verification
REQ-031 K=40, f1=3, f2=10, inits 30/20/10, start, then beat δ=(13,33) -> next cycle pi_even lanes=(0,30,20,10), pi_odd lanes=(13,3,33,23).
REQ-032 Same K with 5 consecutive beats -> exactly 5 out_valid; done only on the 5th; state IDLE afterwards.
REQ-033 Beats with in_valid gaps of 2 cycles -> outputs identical to the gap-free run, with out_valid low in the gap cycles.
REQ-034 start and in_valid asserted together -> no out_valid next cycle; lanes equal the init values.
REQ-035 rst pulse after beat 2 of 5 -> all outputs 0 at once; no done; a new start runs a full 5-beat block correctly.
REQ-036 With the macro defined, theta_0=40 at K=40 -> err=1 and stays 1 until the next start.
